inv_ark_mix_stage: RTL and testbench

- Downstream neighbour of the inverse SubBytes stage in the AES-128 decryption datapath.
- Takes the 128-bit state after InvSubBytes and XORs it with the round key (AddRoundKey).
- Then applies InvMixColumns, or bypasses it on the final round.
- Two-stage registered pipeline with valid/ready handshake on both sides; also counts completed blocks for debug.

---
 rtl/inv_ark_mix_stage.sv | 165 ++++++++++++++++
 tb/tb_inv_ark_mix_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/inv_ark_mix_stage.sv
// AES-128 decryption round tail: AddRoundKey followed by InvMixColumns (bypassed on
// the final round), as a two-stage valid/ready pipeline with a completed-block counter.
module inv_ark_mix_stage #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [127:0]     s_state,
  input  logic [127:0]     s_round_key,
  input  logic             s_last,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [127:0]     m_state,
  output logic             m_last,
  output logic [TAG_W-1:0] m_tag,
  output logic [CNT_W-1:0] blk_count
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multipliers for InvMixColumns, built from doubling chains.
  function automatic logic [7:0] gmul_09(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul_09 = x8 ^ a;
  endfunction

  function automatic logic [7:0] gmul_0b(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul_0b = x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gmul_0d(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul_0d = x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gmul_0e(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul_0e = x8 ^ x4 ^ x2;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = gmul_0e(a0) ^ gmul_0b(a1) ^ gmul_0d(a2) ^ gmul_09(a3);
    b1 = gmul_09(a0) ^ gmul_0e(a1) ^ gmul_0b(a2) ^ gmul_0d(a3);
    b2 = gmul_0d(a0) ^ gmul_09(a1) ^ gmul_0e(a2) ^ gmul_0b(a3);
    b3 = gmul_0b(a0) ^ gmul_0d(a1) ^ gmul_09(a2) ^ gmul_0e(a3);
    inv_mix_col = {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[127-32*i -: 32] = inv_mix_col(s[127-32*i -: 32]);
    end
    inv_mix_columns = r;
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic [127:0]     state_p1_q, state_p1_d;
  logic             last_p1_q, last_p1_d;
  logic [TAG_W-1:0] tag_p1_q, tag_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic [127:0]     state_p2_q, state_p2_d;
  logic             last_p2_q, last_p2_d;
  logic [TAG_W-1:0] tag_p2_q, tag_p2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, adv2, out_hs;

  assign s_ready   = !vld_p1_q || !vld_p2_q || m_ready;
  assign accept    = s_valid && s_ready;
  assign adv2      = vld_p1_q && (!vld_p2_q || m_ready);
  assign out_hs    = vld_p2_q && m_ready;

  assign m_valid   = vld_p2_q;
  assign m_state   = state_p2_q;
  assign m_last    = last_p2_q;
  assign m_tag     = tag_p2_q;
  assign blk_count = cnt_q;

  always_comb begin
    vld_p1_d   = vld_p1_q;
    state_p1_d = state_p1_q;
    last_p1_d  = last_p1_q;
    tag_p1_d   = tag_p1_q;
    vld_p2_d   = vld_p2_q;
    state_p2_d = state_p2_q;
    last_p2_d  = last_p2_q;
    tag_p2_d   = tag_p2_q;
    cnt_d      = cnt_q;

    // Stage 1: AddRoundKey
    if (accept) begin
      vld_p1_d   = 1'b1;
      state_p1_d = s_state ^ s_round_key;
      last_p1_d  = s_last;
      tag_p1_d   = s_tag;
    end else if (adv2) begin
      vld_p1_d   = 1'b0;
    end

    // Stage 2: InvMixColumns or final-round bypass
    if (adv2) begin
      vld_p2_d   = 1'b1;
      state_p2_d = last_p1_q ? state_p1_q : inv_mix_columns(state_p1_q);
      last_p2_d  = last_p1_q;
      tag_p2_d   = tag_p1_q;
    end else if (m_ready) begin
      vld_p2_d   = 1'b0;
    end

    if (out_hs) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      state_p1_q <= '0;
      last_p1_q  <= 1'b0;
      tag_p1_q   <= '0;
      vld_p2_q   <= 1'b0;
      state_p2_q <= '0;
      last_p2_q  <= 1'b0;
      tag_p2_q   <= '0;
      cnt_q      <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      state_p1_q <= state_p1_d;
      last_p1_q  <= last_p1_d;
      tag_p1_q   <= tag_p1_d;
      vld_p2_q   <= vld_p2_d;
      state_p2_q <= state_p2_d;
      last_p2_q  <= last_p2_d;
      tag_p2_q   <= tag_p2_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inv_ark_mix_stage.sv
// Directed bench for inv_ark_mix_stage: key XOR, InvMixColumns vectors, backpressure,
// full throughput, mid-stream reset and counter wrap (second instance with CNT_W = 4).
module tb_inv_ark_mix_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic [127:0] s_state;
  logic [127:0] s_round_key;
  logic         s_last;
  logic [3:0]   s_tag;
  logic         m_ready;

  logic         s_ready, m_valid, m_last;
  logic [127:0] m_state;
  logic [3:0]   m_tag;
  logic [15:0]  blk_count;

  logic         s_ready_w, m_valid_w, m_last_w;
  logic [127:0] m_state_w;
  logic [3:0]   m_tag_w;
  logic [3:0]   blk_count_w;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  inv_ark_mix_stage #(.TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_state(s_state), .s_round_key(s_round_key), .s_last(s_last), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_state(m_state), .m_last(m_last),
    .m_tag(m_tag), .blk_count(blk_count)
  );

  inv_ark_mix_stage #(.TAG_W(4), .CNT_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w),
    .s_state(s_state), .s_round_key(s_round_key), .s_last(s_last), .s_tag(s_tag),
    .m_valid(m_valid_w), .m_ready(m_ready), .m_state(m_state_w), .m_last(m_last_w),
    .m_tag(m_tag_w), .blk_count(blk_count_w)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pipeline empty, m_ready=1, called just after an edge; checks the block two edges later.
  task automatic run_one(input string name, input logic [127:0] st, input logic [127:0] key,
                         input logic last, input logic [3:0] tag, input logic [127:0] exp);
    s_valid = 1'b1; s_state = st; s_round_key = key; s_last = last; s_tag = tag;
    tick();
    s_valid = 1'b0;
    check_val({name, "_nolat1"}, {127'd0, m_valid}, 128'd0);
    tick();
    check_val({name, "_vld"},   {127'd0, m_valid}, 128'd1);
    check_val({name, "_state"}, m_state, exp);
    check_val({name, "_last"},  {127'd0, m_last}, {127'd0, last});
    check_val({name, "_tag"},   {124'd0, m_tag}, {124'd0, tag});
    tick();
    check_val({name, "_drain"}, {127'd0, m_valid}, 128'd0);
  endtask

  logic [127:0] blk;
  logic [127:0] key_a5;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_state = '0; s_round_key = '0;
    s_last = 1'b0; s_tag = '0; m_ready = 1'b1;
    key_a5 = {16{8'ha5}};
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check_val("rst_mvalid", {127'd0, m_valid}, 128'd0);
    check_val("rst_mstate", m_state, 128'd0);
    check_val("rst_cnt",    {112'd0, blk_count}, 128'd0);
    check_val("rst_sready", {127'd0, s_ready}, 128'd1);

    run_one("bypass", 128'd0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'd5,
            128'h000102030405060708090a0b0c0d0e0f);
    check_val("bypass_cnt", {112'd0, blk_count}, 128'd1);

    run_one("imc", 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 128'd0, 1'b0, 4'd6,
            128'hdb135345f20a225c01010101c6c6c6c6);
    run_one("combo", {4{32'h8f4ca0bd}}, {4{32'h01010101}}, 1'b0, 4'd7,
            {4{32'hdb135345}});
    check_val("combo_cnt", {112'd0, blk_count}, 128'd3);

    // Backpressure: fill both stages, then drain back-to-back.
    m_ready = 1'b0; s_valid = 1'b1; s_round_key = '0; s_last = 1'b1;
    s_tag = 4'd1; s_state = {32{4'd1}};
    #1 check_val("bp_rdy1", {127'd0, s_ready}, 128'd1);
    tick();
    s_tag = 4'd2; s_state = {32{4'd2}};
    check_val("bp_rdy2", {127'd0, s_ready}, 128'd1);
    tick();
    s_tag = 4'd3; s_state = {32{4'd3}};
    check_val("bp_rdy3", {127'd0, s_ready}, 128'd0);
    check_val("bp_tag1", {124'd0, m_tag}, 128'd1);
    tick();
    check_val("bp_rdy4",  {127'd0, s_ready}, 128'd0);
    check_val("bp_hold_v", {127'd0, m_valid}, 128'd1);
    check_val("bp_hold_t", {124'd0, m_tag}, 128'd1);
    check_val("bp_hold_s", m_state, {32{4'd1}});
    m_ready = 1'b1;
    #1 check_val("bp_rdy_up", {127'd0, s_ready}, 128'd1);
    tick();
    check_val("bp_out2", {124'd0, m_tag}, 128'd2);
    s_tag = 4'd4; s_state = {32{4'd4}};
    tick();
    check_val("bp_out3", {124'd0, m_tag}, 128'd3);
    check_val("bp_out3s", m_state, {32{4'd3}});
    s_valid = 1'b0;
    tick();
    check_val("bp_out4", {124'd0, m_tag}, 128'd4);
    check_val("bp_out4v", {127'd0, m_valid}, 128'd1);
    tick();
    check_val("bp_empty", {127'd0, m_valid}, 128'd0);
    check_val("bp_cnt", {112'd0, blk_count}, 128'd7);

    // Full throughput: 16 blocks, one per cycle.
    s_round_key = key_a5; s_last = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        s_valid = 1'b1;
        s_state = {16{i[7:0]}};
        s_tag   = i[3:0];
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (i < 16) check_val($sformatf("tp_rdy%0d", i), {127'd0, s_ready}, 128'd1);
      if (i == 1) check_val("tp_lat", {127'd0, m_valid}, 128'd0);
      if (i >= 2) begin
        blk = {16{8'(i - 2)}} ^ key_a5;
        check_val($sformatf("tp_v%0d", i - 2), {127'd0, m_valid}, 128'd1);
        check_val($sformatf("tp_s%0d", i - 2), m_state, blk);
        check_val($sformatf("tp_t%0d", i - 2), {124'd0, m_tag}, {124'd0, 4'(i - 2)});
      end
      tick();
    end
    check_val("tp_empty", {127'd0, m_valid}, 128'd0);
    check_val("tp_cnt", {112'd0, blk_count}, 128'd23);

    // Mid-stream reset with two blocks in flight.
    m_ready = 1'b0; s_valid = 1'b1; s_state = {4{32'hdeadbeef}}; s_round_key = '0;
    tick(); tick();
    s_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_val("mr_mvalid", {127'd0, m_valid}, 128'd0);
    check_val("mr_mstate", m_state, 128'd0);
    check_val("mr_cnt",    {112'd0, blk_count}, 128'd0);
    check_val("mr_sready", {127'd0, s_ready}, 128'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("mr_stale%0d", i), {127'd0, m_valid}, 128'd0);
    end

    // Counter wrap on the CNT_W=4 instance.
    s_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_tag = i[3:0];
      tick();
    end
    s_valid = 1'b0;
    tick(); tick();
    check_val("wrap_cnt4",  {124'd0, blk_count_w}, 128'd1);
    check_val("wrap_cnt16", {112'd0, blk_count}, 128'd17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
